// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU results and FIFO-buffered load returns onto one register file write port
module wb_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH = 3,
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic [REG_ADDR_WIDTH-1:0] alu_waddr,
  input  logic [DATA_WIDTH-1:0]     alu_wdata,
  input  logic                      mem_valid,
  output logic                      mem_ready,
  input  logic [REG_ADDR_WIDTH-1:0] mem_waddr,
  input  logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic                      wena,
  output logic [REG_ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0]     wdata,
  output logic [CNT_WIDTH-1:0]      mem_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [REG_ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic last_grant;
  logic head_req, grant_alu, grant_mem, push;
  // last_grant: 0 = ALU, 1 = MEM; the loser of the previous contention wins the next
  always_comb begin
    head_req = mem_count != '0;
    grant_alu = alu_valid && (!head_req || last_grant);
    grant_mem = head_req && (!alu_valid || !last_grant);
    alu_ready = !rst && grant_alu;
    mem_ready = !rst && mem_count != CNT_WIDTH'(FIFO_DEPTH);
    push = mem_valid && mem_ready;
  end
  always_ff @(posedge clk)
    if (push) begin
      fifo_addr[wr_ptr] <= mem_waddr;
      fifo_data[wr_ptr] <= mem_wdata;
    end
  always_ff @(posedge clk) begin
    if (rst) begin
      wena <= 1'b0;
      waddr <= '0;
      wdata <= '0;
      mem_count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      last_grant <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (grant_mem) rd_ptr <= rd_ptr + 1'b1;
      if (push != grant_mem) mem_count <= push ? mem_count + 1'b1 : mem_count - 1'b1;
      wena <= grant_alu || grant_mem;
      if (grant_alu || grant_mem) begin
        waddr <= grant_mem ? fifo_addr[rd_ptr] : alu_waddr;
        wdata <= grant_mem ? fifo_data[rd_ptr] : alu_wdata;
        last_grant <= grant_mem;
      end
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scenario checks for the writeback arbiter
module tb_wb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic alu_valid = 1'b0, mem_valid = 1'b0;
  logic alu_ready, mem_ready, wena;
  logic [4:0] alu_waddr = '0, mem_waddr = '0, waddr;
  logic [31:0] alu_wdata = '0, mem_wdata = '0, wdata;
  logic [2:0] mem_count;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .wena(wena), .waddr(waddr), .wdata(wdata), .mem_count(mem_count)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    alu_valid = 0;
    mem_valid = 0;
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    tick();
    tick();
    alu_valid = 1;
    mem_valid = 1;
    #1;
    total++; if (alu_ready !== 1'b0) begin bad++; $display("FAIL rst_alu_ready got=%b exp=0", alu_ready); end
    total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL rst_mem_ready got=%b exp=0", mem_ready); end
    alu_valid = 0;
    mem_valid = 0;
    tick();
    rst = 0;
    #1;
    total++; if (mem_ready !== 1'b1) begin bad++; $display("FAIL rel_mem_ready got=%b exp=1", mem_ready); end
    total++; if ({wena, waddr, wdata, mem_count} !== 41'd0) begin bad++; $display("FAIL rst_regs got=%b/%h/%h/%0d exp=0", wena, waddr, wdata, mem_count); end
  endtask

  task automatic test_lone_alu();
    do_reset();
    alu_valid = 1;
    alu_waddr = 5;
    alu_wdata = 32'hDEADBEEF;
    #1;
    total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL alu_ready got=%b exp=1", alu_ready); end
    tick();
    alu_valid = 0;
    total++; if ({wena, waddr, wdata} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin bad++; $display("FAIL alu_write got=%b/%0d/%h exp=1/5/deadbeef", wena, waddr, wdata); end
    tick();
    total++; if (wena !== 1'b0) begin bad++; $display("FAIL alu_idle got=%b exp=0", wena); end
  endtask

  task automatic test_lone_load();
    do_reset();
    mem_valid = 1;
    mem_waddr = 3;
    mem_wdata = 32'h11;
    tick();
    mem_valid = 0;
    total++; if ({wena, mem_count} !== {1'b0, 3'd1}) begin bad++; $display("FAIL load_c1 got=%b/%0d exp=0/1", wena, mem_count); end
    tick();
    total++; if ({wena, waddr, wdata, mem_count} !== {1'b1, 5'd3, 32'h11, 3'd0}) begin bad++; $display("FAIL load_write got=%b/%0d/%h/%0d exp=1/3/11/0", wena, waddr, wdata, mem_count); end
    tick();
    total++; if (wena !== 1'b0) begin bad++; $display("FAIL load_idle got=%b exp=0", wena); end
  endtask

  task automatic test_contention();
    logic [4:0] exp_a [5] = '{7, 1, 8, 2, 9};
    logic exp_alu [5] = '{1, 0, 1, 0, 1};
    logic [4:0] alu_seq [3] = '{7, 8, 9};
    int ai = 0;
    do_reset();
    mem_valid = 1; mem_waddr = 1; mem_wdata = 32'h101;
    tick();
    mem_waddr = 2; mem_wdata = 32'h102;
    for (int i = 0; i < 5; i++) begin
      alu_valid = 1;
      alu_waddr = alu_seq[ai];
      alu_wdata = 32'h700 + ai;
      #1;
      total++; if (alu_ready !== exp_alu[i]) begin bad++; $display("FAIL cont_ready[%0d] got=%b exp=%b", i, alu_ready, exp_alu[i]); end
      tick();
      mem_valid = 0;
      if (exp_alu[i]) ai++;
      total++; if ({wena, waddr} !== {1'b1, exp_a[i]}) begin bad++; $display("FAIL cont_write[%0d] got=%b/%0d exp=1/%0d", i, wena, waddr, exp_a[i]); end
    end
    alu_valid = 0;
    tick();
    total++; if ({wena, mem_count} !== 4'd0) begin bad++; $display("FAIL cont_end got=%b/%0d exp=0/0", wena, mem_count); end
  endtask

  task automatic test_fifo_stream();
    logic [2:0] exp_cnt [9] = '{0, 1, 1, 1, 1, 1, 1, 0, 0};
    do_reset();
    for (int k = 0; k < 9; k++) begin
      mem_valid = k < 6;
      mem_waddr = 5'(k);
      mem_wdata = 32'h50 + k;
      total++; if (mem_count !== exp_cnt[k]) begin bad++; $display("FAIL stream_cnt[%0d] got=%0d exp=%0d", k, mem_count, exp_cnt[k]); end
      if (k >= 2 && k <= 7) begin
        total++; if ({wena, waddr, wdata} !== {1'b1, 5'(k - 2), 32'h50 + k - 2}) begin bad++; $display("FAIL stream_wr[%0d] got=%b/%0d/%h exp=1/%0d/%h", k, wena, waddr, wdata, k - 2, 32'h50 + k - 2); end
      end else begin
        total++; if (wena !== 1'b0) begin bad++; $display("FAIL stream_idle[%0d] got=%b exp=0", k, wena); end
      end
      tick();
    end
    mem_valid = 0;
  endtask

  task automatic test_fifo_full();
    logic [2:0] exp_cnt [12] = '{0, 1, 1, 2, 2, 3, 3, 4, 3, 4, 3, 4};
    do_reset();
    alu_valid = 1;
    mem_valid = 1;
    for (int k = 0; k < 12; k++) begin
      alu_waddr = 5'd20;
      mem_waddr = 5'(k);
      #1;
      total++; if (mem_count !== exp_cnt[k]) begin bad++; $display("FAIL full_cnt[%0d] got=%0d exp=%0d", k, mem_count, exp_cnt[k]); end
      total++; if (mem_ready !== (exp_cnt[k] != 3'd4)) begin bad++; $display("FAIL full_ready[%0d] got=%b exp=%b", k, mem_ready, exp_cnt[k] != 3'd4); end
      total++; if (alu_ready !== (k % 2 == 0)) begin bad++; $display("FAIL full_alu[%0d] got=%b exp=%b", k, alu_ready, k % 2 == 0); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    total++; if (mem_count !== 3'd3) begin bad++; $display("FAIL mid_pre_cnt got=%0d exp=3", mem_count); end
    rst = 1;
    #1;
    total++; if ({alu_ready, mem_ready} !== 2'b00) begin bad++; $display("FAIL mid_ready got=%b%b exp=00", alu_ready, mem_ready); end
    tick();
    rst = 0;
    alu_valid = 0;
    mem_valid = 0;
    total++; if ({wena, waddr, mem_count} !== 9'd0) begin bad++; $display("FAIL mid_regs got=%b/%0d/%0d exp=0/0/0", wena, waddr, mem_count); end
    tick();
    total++; if ({wena, mem_count} !== 4'd0) begin bad++; $display("FAIL mid_stale got=%b/%0d exp=0/0", wena, mem_count); end
    mem_valid = 1; mem_waddr = 5'h11; mem_wdata = 32'h111;
    tick();
    mem_valid = 0;
    alu_valid = 1; alu_waddr = 5'h12; alu_wdata = 32'h222;
    #1;
    total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL mid_first got=%b exp=1", alu_ready); end
    tick();
    alu_valid = 0;
    total++; if ({wena, waddr} !== {1'b1, 5'h12}) begin bad++; $display("FAIL mid_w0 got=%b/%h exp=1/12", wena, waddr); end
    tick();
    total++; if ({wena, waddr, wdata} !== {1'b1, 5'h11, 32'h111}) begin bad++; $display("FAIL mid_w1 got=%b/%h/%h exp=1/11/111", wena, waddr, wdata); end
  endtask

  task automatic test_same_addr();
    logic [31:0] reg4 = '0;
    do_reset();
    mem_valid = 1; mem_waddr = 4; mem_wdata = 32'hB;
    tick();
    mem_valid = 0;
    alu_valid = 1; alu_waddr = 4; alu_wdata = 32'hA;
    tick();
    alu_valid = 0;
    if (wena && waddr == 5'd4) reg4 = wdata;
    total++; if (reg4 !== 32'hA) begin bad++; $display("FAIL same_first got=%h exp=a", reg4); end
    tick();
    if (wena && waddr == 5'd4) reg4 = wdata;
    total++; if (reg4 !== 32'hB) begin bad++; $display("FAIL same_final got=%h exp=b", reg4); end
  endtask

  initial begin
    test_reset();
    test_lone_alu();
    test_lone_load();
    test_contention();
    test_fifo_stream();
    test_fifo_full();
    test_reset_mid();
    test_same_addr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter for the GPU core. It merges ALU results and memory load returns onto the register file's single write port. Load returns pass through a small FIFO, and ALU results are granted directly. When both sources are pending, a round-robin grant picks one. The block sits directly upstream of the register file: its registered `wena`/`waddr`/`wdata` outputs drive the register file write port.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: load-return FIFO entries, must be a power of 2 and at least 2.
- `CNT_WIDTH`, default 3: width of `mem_count`, equal to log2(FIFO_DEPTH)+1.
- Data and address widths are `DATA_WIDTH` and `REG_ADDR_WIDTH`, taken from `defines.v`.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset, sampled on the `clk` rising edge.
- `alu_valid`, input, 1: ALU result present.
- `alu_ready`, output, 1: ALU result accepted this cycle (combinational).
- `alu_waddr`, input, `REG_ADDR_WIDTH`: ALU destination register.
- `alu_wdata`, input, `DATA_WIDTH`: ALU result.
- `mem_valid`, input, 1: load return present.
- `mem_ready`, output, 1: FIFO can accept.
- `mem_waddr`, input, `REG_ADDR_WIDTH`: load destination register.
- `mem_wdata`, input, `DATA_WIDTH`: load data.
- `wena`, output, 1: register file write enable (registered).
- `waddr`, output, `REG_ADDR_WIDTH`: register file write address (registered).
- `wdata`, output, `DATA_WIDTH`: register file write data (registered).
- `mem_count`, output, `CNT_WIDTH`: current FIFO occupancy, 0 to FIFO_DEPTH.

## Operation
- **Handshake.** A transfer happens on a cycle where valid and ready are both high. Producers hold valid, addr and data stable until the transfer.
- **Load FIFO.**
  - `mem_ready = !rst && (mem_count != FIFO_DEPTH)`. It is computed from the current count only, so a full FIFO never accepts, even on a cycle where it pops.
  - Push is `mem_valid && mem_ready`. Pop happens when the FIFO head is granted.
  - Push and pop in the same cycle leave the count unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - There is no bypass: an entry pushed in cycle N is poppable in N+1 at the earliest.
- **Arbitration.** The requesters are the ALU (`alu_valid`) and the FIFO head (`mem_count != 0`).
  - If only one requests, it is granted.
  - If both request, the one not granted most recently wins.
  - A 1-bit `last_grant` register (0=ALU, 1=MEM) updates on every grant. It resets to MEM, so the first contention goes to the ALU.
  - Starvation bound: a requester that keeps its request waits at most 1 cycle.
- **ALU ready.** `alu_ready` = ALU granted, and is 0 while `rst` is high.
- **Write port.**
  - On a grant, the next edge loads `wena=1` with the granted addr/data.
  - With no grant, `wena=0`; `waddr`/`wdata` hold their last values.
- **Same waddr.** When both sources target the same waddr in one cycle, the writes go out in grant order: the later write wins in the register file. Ordering between the units is the scoreboard's responsibility, not this block's.
- **Reset** (synchronous, on the `rst` edge): `wena=0`, `waddr=0`, `wdata=0`, `mem_count=0`, both pointers 0, `last_grant=MEM`.
  - FIFO contents are discarded, and an in-flight grant on the reset cycle is dropped.
  - `alu_ready` and `mem_ready` are 0 while `rst` is high. `mem_ready` is 1 in the first cycle after release.

## Timing
- ALU latency: accepted in cycle N, so `wena`=1 in N+1. The register file commits at the N+1 edge and bypasses reads during N+1.
- Load latency: pushed in cycle N, granted at the earliest in N+1, so `wena` in N+2.
- Throughput: one register file write per cycle. The sustained combined rate is at most 1 per cycle.
- `mem_count` is registered and updates at the edge after the push/pop.
- No combinational path from `alu_valid`/`mem_valid` to `mem_ready`. `alu_ready` depends combinationally on `alu_valid`, `mem_count` and `last_grant`.

## Test plan
- **Lone ALU.** After reset, `alu_valid=1`, `alu_waddr=5`, `alu_wdata=0xDEADBEEF` for 1 cycle.
  - `alu_ready=1` that cycle.
  - Next cycle `wena=1`, `waddr=5`, `wdata=0xDEADBEEF`; the cycle after, `wena=0`.
- **Lone load.** Push `mem_waddr=3`, `mem_wdata=0x11` in cycle 0.
  - `mem_count=1` at cycle 1, with grant in cycle 1.
  - `wena=1`, `waddr=3` in cycle 2, and `mem_count` back to 0.
- **Contention.** FIFO holds 2 entries (waddr 1, 2) and `alu_valid` is held with waddr 7, 8, 9 over successive transfers.
  - Write sequence on `waddr`: 7, 1, 8, 2, 9. This checks the starting priority, the alternation and the 1-cycle starvation bound.
- **FIFO full.** Hold `mem_valid=1` with no ALU traffic, driving writes 0–5.
  - FIFO drains 1 per cycle, `mem_count` never exceeds 4, and all 6 writes appear in order.
  - A separate run forces the full case by keeping the ALU granted every other cycle. Expect `mem_ready=0` exactly when `mem_count=4`, including on a cycle where a pop happens.
- **Reset mid-operation.** Assert `rst` for 1 cycle with 3 entries queued and `alu_valid=1`.
  - Next cycle: `wena=0`, `mem_count=0`, `alu_ready=0` and `mem_ready=0` during `rst`.
  - After release, no stale writes appear, and the first contention grants the ALU.
- **Same address.** ALU and FIFO head both target waddr 4 with data 0xA and 0xB, with `last_grant=MEM`.
  - Writes go out as 0xA then 0xB, so register 4 ends at 0xB.
